// File: rtl/parking_pkg.sv
// Shared constants, event FSM state type and popcount helper for the parking slot sensor.
`timescale 1ns/1ps
package parking_pkg;

  localparam int NUM_SLOTS  = 8;
  localparam int SLOT_IDX_W = 3;
  localparam int COUNT_W    = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } evt_state_t;

  function automatic logic [COUNT_W-1:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [COUNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      sum = sum + COUNT_W'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/slot_debounce.sv
// One parking slot: 2-flop synchronizer followed by the debounced occupied bit.
// Macro PARK_DEBOUNCE_EN selects the counter-based debounce; otherwise the synchronized bit is registered once.
`timescale 1ns/1ps
module slot_debounce
  import parking_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic switch_raw,
  output logic occupied
);

  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= switch_raw;
      sync_q2 <= sync_q1;
    end
  end

`ifdef PARK_DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Any cycle where the input agrees with the current state restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      occupied <= 1'b0;
    end else if (sync_q2 == occupied) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt      <= '0;
      occupied <= ~occupied;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      occupied <= 1'b0;
    end else begin
      occupied <= sync_q2;
    end
  end
`endif

endmodule

// File: rtl/parking_slot_sensor.sv
// Eight-slot parking occupancy sensor: per-slot debounce, registered car count and a valid/ready event stream.
// Debounce is enabled with macro PARK_DEBOUNCE_EN (see slot_debounce).
`timescale 1ns/1ps
module parking_slot_sensor
  import parking_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SLOTS-1:0]  switches,
  output logic [NUM_SLOTS-1:0]  occupied,
  output logic [COUNT_W-1:0]    car_count,
  output logic                  full,
  output logic                  empty,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [SLOT_IDX_W-1:0] evt_slot,
  output logic                  evt_arrive,
  output logic                  evt_ovf,
  input  logic                  ovf_clr
);

  evt_state_t state, state_next;

  logic [NUM_SLOTS-1:0]  occ_prev;
  logic [NUM_SLOTS-1:0]  toggled;
  logic [NUM_SLOTS-1:0]  pending, pending_next;
  logic [NUM_SLOTS-1:0]  pdir, pdir_next;
  logic [NUM_SLOTS-1:0]  pend_clr;
  logic [COUNT_W-1:0]    occ_count;
  logic [SLOT_IDX_W-1:0] sel;
  logic                  found;
  logic                  ovf_set;
  logic                  evt_valid_next;
  logic                  evt_arrive_next;
  logic [SLOT_IDX_W-1:0] evt_slot_next;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    slot_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .switch_raw (switches[gi]),
      .occupied   (occupied[gi])
    );
  end

  assign occ_count = popcount(occupied);
  assign toggled   = occupied ^ occ_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_prev  <= '0;
      car_count <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      occ_prev  <= occupied;
      car_count <= occ_count;
      full      <= (occ_count == COUNT_W'(NUM_SLOTS));
      empty     <= (occ_count == '0);
    end
  end

  // A slot toggling in the same cycle its event is being loaded is a fresh event, not an overwrite.
  always_comb begin
    state_next      = state;
    evt_valid_next  = evt_valid;
    evt_slot_next   = evt_slot;
    evt_arrive_next = evt_arrive;
    pend_clr        = '0;
    sel             = '0;
    found           = 1'b0;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (pending[i] && !found) begin
        sel   = SLOT_IDX_W'(i);
        found = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          pend_clr[sel]   = 1'b1;
          evt_slot_next   = sel;
          evt_arrive_next = pdir[sel];
          evt_valid_next  = 1'b1;
          state_next      = PRESENT;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          evt_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        evt_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase

    pending_next = (pending & ~pend_clr) | toggled;
    pdir_next    = (pdir & ~toggled) | (occupied & toggled);
    ovf_set      = |(toggled & pending & ~pend_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      pdir       <= '0;
      evt_valid  <= 1'b0;
      evt_slot   <= '0;
      evt_arrive <= 1'b0;
      evt_ovf    <= 1'b0;
    end else begin
      state      <= state_next;
      pending    <= pending_next;
      pdir       <= pdir_next;
      evt_valid  <= evt_valid_next;
      evt_slot   <= evt_slot_next;
      evt_arrive <= evt_arrive_next;
      if (ovf_set) begin
        evt_ovf <= 1'b1;
      end else if (ovf_clr) begin
        evt_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parking_slot_sensor.sv
// Directed self-checking bench for parking_slot_sensor with DEB_CYCLES=16.
// Expected latencies follow PARK_DEBOUNCE_EN: 2+DEB_CYCLES with debounce, 3 without.
`timescale 1ns/1ps
module tb_parking_slot_sensor;

  localparam int DEB = 16;
`ifdef PARK_DEBOUNCE_EN
  localparam int LAT    = DEB + 2;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 3;
  localparam bit DEB_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] switches;
  logic [7:0] occupied;
  logic [3:0] car_count;
  logic       full;
  logic       empty;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_slot;
  logic       evt_arrive;
  logic       evt_ovf;
  logic       ovf_clr;

  int errors = 0;
  int checks = 0;

  parking_slot_sensor #(.DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .switches   (switches),
    .occupied   (occupied),
    .car_count  (car_count),
    .full       (full),
    .empty      (empty),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_slot   (evt_slot),
    .evt_arrive (evt_arrive),
    .evt_ovf    (evt_ovf),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset;
    rst = 1'b1; switches = 8'h00; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (occupied !== 8'h00) begin errors++; $display("[TB] FAIL reset_occ: got %h want 00", occupied); end
    checks++; if (car_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", car_count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: empty=%b full=%b want 1/0", empty, full); end
    checks++; if (evt_valid !== 1'b0 || evt_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_evt: valid=%b ovf=%b want 0/0", evt_valid, evt_ovf); end
    rst = 1'b0;
  endtask

  task automatic test_single_arrive;
    int n;
    @(negedge clk); switches = 8'h01;
    repeat (LAT - 1) @(negedge clk);
    checks++; if (occupied !== 8'h00) begin errors++; $display("[TB] FAIL arrive_early: got %h want 00", occupied); end
    @(negedge clk);
    checks++; if (occupied !== 8'h01) begin errors++; $display("[TB] FAIL arrive_occ: got %h want 01", occupied); end
    checks++; if (car_count !== 4'd0) begin errors++; $display("[TB] FAIL count_lag: got %0d want 0", car_count); end
    @(negedge clk);
    checks++; if (car_count !== 4'd1 || empty !== 1'b0 || full !== 1'b0) begin errors++; $display("[TB] FAIL arrive_count: count=%0d empty=%b full=%b want 1/0/0", car_count, empty, full); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL arrive_valid_early: got %b want 0", evt_valid); end
    @(negedge clk);
    checks++; if (evt_valid !== 1'b1 || evt_slot !== 3'd0 || evt_arrive !== 1'b1) begin errors++; $display("[TB] FAIL arrive_evt: valid=%b slot=%0d arrive=%b want 1/0/1", evt_valid, evt_slot, evt_arrive); end
    repeat (3) @(negedge clk);
    checks++; if (evt_valid !== 1'b1 || evt_slot !== 3'd0 || evt_arrive !== 1'b1) begin errors++; $display("[TB] FAIL arrive_hold: valid=%b slot=%0d arrive=%b want 1/0/1", evt_valid, evt_slot, evt_arrive); end
    evt_ready = 1'b1;
    @(negedge clk);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL arrive_accept: valid=%b want 0", evt_valid); end
    evt_ready = 1'b0;
    switches = 8'h00;
    n = 0;
    while (evt_valid !== 1'b1 && n < LAT + 10) begin @(negedge clk); n++; end
    checks++; if (evt_valid !== 1'b1 || evt_slot !== 3'd0 || evt_arrive !== 1'b0) begin errors++; $display("[TB] FAIL depart_evt: valid=%b slot=%0d arrive=%b want 1/0/0", evt_valid, evt_slot, evt_arrive); end
    checks++; if (empty !== 1'b1 || car_count !== 4'd0) begin errors++; $display("[TB] FAIL depart_empty: empty=%b count=%0d want 1/0", empty, car_count); end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic test_glitch;
    int  nev;
    logic seen;
    seen = 1'b0; nev = 0;
    @(negedge clk); switches = 8'h08; evt_ready = 1'b1;
    repeat (10) begin @(negedge clk); if (occupied !== 8'h00) seen = 1'b1; if (evt_valid === 1'b1) nev++; end
    switches = 8'h00;
    repeat (LAT + 12) begin @(negedge clk); if (occupied !== 8'h00) seen = 1'b1; if (evt_valid === 1'b1) nev++; end
    checks++; if (seen !== !DEB_ON) begin errors++; $display("[TB] FAIL glitch_seen: got %b want %b", seen, !DEB_ON); end
    checks++; if (nev != (DEB_ON ? 0 : 2)) begin errors++; $display("[TB] FAIL glitch_events: got %0d want %0d", nev, DEB_ON ? 0 : 2); end
    checks++; if (occupied !== 8'h00 || evt_ovf !== 1'b0) begin errors++; $display("[TB] FAIL glitch_end: occ=%h ovf=%b want 00/0", occupied, evt_ovf); end
    evt_ready = 1'b0;
  endtask

  task automatic test_all_change(input logic [7:0] target);
    int nev;
    logic exp_arrive;
    exp_arrive = (target == 8'hFF);
    nev = 0;
    @(negedge clk); switches = target; evt_ready = 1'b1;
    repeat (LAT + 40) begin
      @(negedge clk);
      if (evt_valid === 1'b1) begin
        checks++;
        if (evt_slot !== 3'(nev) || evt_arrive !== exp_arrive) begin
          errors++; $display("[TB] FAIL all_evt%0d: slot=%0d arrive=%b want %0d/%b", nev, evt_slot, evt_arrive, nev, exp_arrive);
        end
        nev++;
      end
    end
    checks++; if (nev != 8) begin errors++; $display("[TB] FAIL all_count_events: got %0d want 8", nev); end
    checks++; if (full !== exp_arrive || empty !== !exp_arrive || car_count !== (exp_arrive ? 4'd8 : 4'd0)) begin
      errors++; $display("[TB] FAIL all_flags: full=%b empty=%b count=%0d target=%h", full, empty, car_count, target);
    end
    checks++; if (evt_ovf !== 1'b0) begin errors++; $display("[TB] FAIL all_ovf: got %b want 0", evt_ovf); end
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow;
    int n, nev;
    @(negedge clk); evt_ready = 1'b0; switches = 8'h01;
    n = 0;
    while (evt_valid !== 1'b1 && n < LAT + 10) begin @(negedge clk); n++; end
    checks++; if (evt_valid !== 1'b1 || evt_slot !== 3'd0) begin errors++; $display("[TB] FAIL ovf_blocker: valid=%b slot=%0d want 1/0", evt_valid, evt_slot); end
    switches = 8'h05;
    repeat (LAT + 3) @(negedge clk);
    switches = 8'h01;
    repeat (LAT + 3) @(negedge clk);
    checks++; if (evt_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b want 1", evt_ovf); end
    checks++; if (evt_valid !== 1'b1 || evt_slot !== 3'd0 || evt_arrive !== 1'b1) begin errors++; $display("[TB] FAIL ovf_hold: valid=%b slot=%0d arrive=%b want 1/0/1", evt_valid, evt_slot, evt_arrive); end
    checks++; if (occupied !== 8'h01) begin errors++; $display("[TB] FAIL ovf_occ: got %h want 01", occupied); end
    evt_ready = 1'b1;
    nev = 0;
    repeat (10) begin
      if (evt_valid === 1'b1) begin
        checks++;
        if (nev == 0 && (evt_slot !== 3'd0 || evt_arrive !== 1'b1)) begin
          errors++; $display("[TB] FAIL ovf_evt0: slot=%0d arrive=%b want 0/1", evt_slot, evt_arrive);
        end else if (nev == 1 && (evt_slot !== 3'd2 || evt_arrive !== 1'b0)) begin
          errors++; $display("[TB] FAIL ovf_evt1: slot=%0d arrive=%b want 2/0", evt_slot, evt_arrive);
        end else if (nev > 1) begin
          errors++; $display("[TB] FAIL ovf_extra: slot=%0d arrive=%b unexpected", evt_slot, evt_arrive);
        end
        nev++;
      end
      @(negedge clk);
    end
    checks++; if (nev != 2) begin errors++; $display("[TB] FAIL ovf_events: got %0d want 2", nev); end
    checks++; if (evt_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b want 1", evt_ovf); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (evt_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b want 0", evt_ovf); end
    switches = 8'h00;
    repeat (LAT + 8) @(negedge clk);
    checks++; if (empty !== 1'b1 || evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleanup: empty=%b valid=%b want 1/0", empty, evt_valid); end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n, nev;
    logic early;
    @(negedge clk); evt_ready = 1'b0; switches = 8'h01;
    n = 0;
    while (evt_valid !== 1'b1 && n < LAT + 10) begin @(negedge clk); n++; end
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pre_valid: got %b want 1", evt_valid); end
    switches = 8'h03;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (occupied !== 8'h00 || car_count !== 4'd0) begin errors++; $display("[TB] FAIL rmid_occ: occ=%h count=%0d want 00/0", occupied, car_count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL rmid_flags: empty=%b full=%b want 1/0", empty, full); end
    checks++; if (evt_valid !== 1'b0 || evt_ovf !== 1'b0 || evt_slot !== 3'd0 || evt_arrive !== 1'b0) begin
      errors++; $display("[TB] FAIL rmid_evt: valid=%b ovf=%b slot=%0d arrive=%b want 0/0/0/0", evt_valid, evt_ovf, evt_slot, evt_arrive);
    end
    rst = 1'b0;
    early = 1'b0;
    repeat (LAT - 1) begin @(negedge clk); if (occupied !== 8'h00 || evt_valid !== 1'b0) early = 1'b1; end
    checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL rmid_early: activity before debounce, got %b want 0", early); end
    evt_ready = 1'b1;
    nev = 0;
    repeat (12) begin
      @(negedge clk);
      if (evt_valid === 1'b1) begin
        checks++;
        if (evt_slot !== 3'(nev) || evt_arrive !== 1'b1) begin
          errors++; $display("[TB] FAIL rmid_evt%0d: slot=%0d arrive=%b want %0d/1", nev, evt_slot, evt_arrive, nev);
        end
        nev++;
      end
    end
    checks++; if (nev != 2 || occupied !== 8'h03) begin errors++; $display("[TB] FAIL rmid_after: events=%0d occ=%h want 2/03", nev, occupied); end
    switches = 8'h00;
    repeat (LAT + 12) @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; switches = 8'h00; evt_ready = 1'b0; ovf_clr = 1'b0;
    $display("[TB] start, LAT=%0d debounce=%0b", LAT, DEB_ON);
    test_reset();
    test_single_arrive();
    test_glitch();
    test_all_change(8'hFF);
    test_all_change(8'h00);
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parking_slot_sensor.md
PARKING_SLOT_SENSOR -- requirements
Module: parking_slot_sensor

Interface
REQ-001 Parameter DEB_CYCLES SHALL default to 1000000 and set the debounce stability window in clk cycles (10 ms at 100 MHz).
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 switches  input  8  raw per-slot occupancy sensors, asynchronous, bit i = slot i.
REQ-005 occupied  output  8  debounced occupancy vector, bit i = 1 means slot i holds a car.
REQ-006 car_count  output  4  number of set bits in occupied, 0..8.
REQ-007 full / empty  output  1 each  car_count==8 / car_count==0.
REQ-008 evt_valid  output  1  an arrive/depart event is presented.
REQ-009 evt_ready  input  1  consumer accepts the event.
REQ-010 evt_slot  output  3  slot index of the presented event.
REQ-011 evt_arrive  output  1  1 = arrival (0->1), 0 = departure (1->0).
REQ-012 evt_ovf  output  1  sticky: an event was overwritten before delivery.
REQ-013 ovf_clr  input  1  single-cycle pulse clearing evt_ovf.

Function
REQ-014 Each switches bit SHALL pass a 2-flop synchronizer before any other use.
REQ-015 Per slot, a counter SHALL increment while the synchronized bit differs from occupied[i] and SHALL clear whenever they match.
REQ-016 When the counter reaches DEB_CYCLES-1 while still differing, occupied[i] SHALL toggle next cycle and the counter SHALL clear; total latency from a stable input change is 2 + DEB_CYCLES cycles.
REQ-017 Glitches shorter than DEB_CYCLES cycles SHALL produce no change on occupied.
REQ-018 car_count, full and empty SHALL be registered, updating one cycle after occupied.
REQ-019 Each occupied toggle SHALL set pending[i] and record its direction in pdir[i].
REQ-020 If pending[i] is already set when slot i toggles, pdir[i] SHALL be overwritten, pending[i] SHALL stay set and evt_ovf SHALL set; when set and ovf_clr coincide, set wins.
REQ-021 Event FSM states SHALL be IDLE and PRESENT; in IDLE with any pending bit, it SHALL load the lowest-index pending slot into evt_slot/evt_arrive, clear that pending bit, assert evt_valid and go to PRESENT.
REQ-022 A toggle of the slot being cleared in the same cycle SHALL re-set pending with the new direction and SHALL NOT set evt_ovf.
REQ-023 In PRESENT, evt_slot/evt_arrive/evt_valid SHALL hold stable until evt_valid&&evt_ready, after which it returns to IDLE with evt_valid low for one cycle (at most one event per 2 cycles).
REQ-024 Debounce and counting SHALL continue regardless of evt_ready back-pressure.

Reset
REQ-025 rst SHALL clear synchronizers, debounce counters, occupied, pending, pdir, evt_slot, evt_arrive, evt_valid and evt_ovf to 0; car_count=0, empty=1, full=0; FSM to IDLE.
REQ-026 rst asserted mid-debounce or mid-handshake SHALL discard all in-flight state; no event SHALL be emitted for occupancy present at reset release until it passes debounce.

Configuration
REQ-027 Macro PARK_DEBOUNCE_EN defined: debounce per REQ-015..017; undefined: occupied[i] SHALL equal the synchronizer output registered once (latency 3 cycles), DEB_CYCLES ignored; all other behaviour unchanged.

Structure
REQ-028 Package parking_pkg SHALL hold NUM_SLOTS=8, SLOT_IDX_W=3, COUNT_W=4 and the event FSM state enum; the existing display stage consumes car_count of width COUNT_W.
REQ-029 Sub-module slot_debounce (synchronizer + counter + occupied bit for one slot) SHALL be instantiated NUM_SLOTS times via generate.

Verification (DEB_CYCLES=16)
REQ-030 switches=0x01 held -> occupied=0x01 after 18 cycles, car_count=1 one cycle later, event slot 0 arrive.
REQ-031 switches bit 3 pulsed high 10 cycles -> occupied unchanged, no event.
REQ-032 switches 0x00->0xFF simultaneously, evt_ready=1 -> full=1, events slots 0..7 in ascending order, all arrive, evt_ovf=0.
REQ-033 evt_ready=0, slot 2 arrives then departs -> one event slot 2 depart on release, evt_ovf=1; ovf_clr pulse -> evt_ovf=0.
REQ-034 rst asserted while evt_valid=1 and counters mid-count -> next cycle all outputs per REQ-025, evt_valid=0.
